sdram_control_if: RTL and testbench
===================================

// Module: sdram_control_if
// PURPOSE
//  Host-side control interface placed directly upstream of the SDRAM command generator.
//  - Decodes the 3-bit host CMD into one-hot command levels and latches the host address.
//  - Runs the power-up init sequence: wait, PRECHARGE, N x REFRESH, LOAD_MODE.
//  - Owns the periodic refresh timer (REF_REQ/REF_ACK handshake with the command stage).
// PARAMETERS
//  ASIZE         23     host/SDRAM address width
//  INIT_PER      24000  power-up wait, in CLK cycles, INIT_REQ held high
//  REF_PER       1024   refresh interval, in CLK cycles
//  INIT_REF_CNT  8      auto-refreshes issued during init (>=1)
// PORTS
//  CLK        in   1      clock; all logic on rising edge
//  RESET_N    in   1      asynchronous, active-low reset
//  CMD        in   3      000 NOP, 001 READA, 010 WRITEA, 011 REFRESH, 100 PRECHARGE, 101 LOAD_MODE; 11x = NOP
//  ADDR       in   ASIZE  host address for CMD
//  CM_ACK     in   1      command accepted, from the command stage
//  REF_ACK    in   1      refresh request accepted, from the command stage
//  NOP        out  1      decoded idle level
//  READA/WRITEA/REFRESH/PRECHARGE/LOAD_MODE  out 1 each  decoded command levels (at most one high)
//  SADDR      out  ASIZE  registered address to the command stage
//  REF_REQ    out  1      periodic refresh request
//  INIT_REQ   out  1      init hold to the command stage
//  CMD_ACK    out  1      one-cycle accept pulse to the host
//  INIT_DONE  out  1      high once the init sequence completes
// BEHAVIOUR
//  Reset (async): INIT_REQ=1, NOP=1, all other outputs 0, SADDR=0, FSM=PWR_WAIT, counters cleared.
//  Reset mid-operation: outputs take reset values immediately; init restarts from PWR_WAIT.
//  FSM states:
//   PWR_WAIT: INIT_REQ=1; count INIT_PER cycles. At the count end: INIT_REQ<=0, go to PRE.
//   PRE:      PRECHARGE=1 until CM_ACK is sampled high. Then drop PRECHARGE, go to ACKLOW.
//   REF:      REFRESH=1 until CM_ACK. Then increment the refresh count and go to ACKLOW.
//   ACKLOW:   all command levels 0 until CM_ACK=0. Then the next step is chosen:
//             - after PRE: go to REF;
//             - after a REF with the count below INIT_REF_CNT: go to REF;
//             - otherwise: go to LMR.
//   LMR:      LOAD_MODE=1 until CM_ACK; SADDR=0. Then INIT_DONE<=1, go to RUN.
//   RUN:      decode CMD each cycle into registered levels, 1-cycle latency.
//  Host commands in any state other than RUN: ignored. No levels asserted, SADDR unchanged, no CMD_ACK.
//  RUN handshake:
//   - A non-NOP CMD registers its level and SADDR<=ADDR on the same edge.
//   - The level is held while CMD is held.
//   - The cycle after CM_ACK=1 is sampled: level<=0, CMD_ACK<=1 for exactly one cycle, set the block flag.
//   - While blocked, no level re-asserts. The block clears when CMD returns to NOP.
//   - A CMD change without an intervening NOP is treated as held (still blocked).
//  NOP output = ~|(READA,WRITEA,REFRESH,PRECHARGE,LOAD_MODE).
//  Refresh timer:
//   - Held at REF_PER-1 until INIT_DONE, then counts down once per cycle.
//   - At 0: REF_REQ<=1 and the counter reloads REF_PER-1.
//   - REF_REQ holds until REF_ACK=1 is sampled, then clears on the next edge.
//   - Expiry while REF_REQ is already set: REF_REQ stays 1, a single request only (no queueing).
//   - Expiry on the same cycle REF_ACK is sampled: expiry wins, REF_REQ stays 1.
//  Counters are sized $clog2 of their parameter and saturate-free (reload or stop only).
// STRUCTURE
//  Package sdram_pkg:
//   - CMD encodings: CMD_NOP, CMD_READA, CMD_WRITEA, CMD_REFRESH, CMD_PRECHARGE, CMD_LOAD_MODE.
//   - FSM state enum.
//  Sub-module sdram_refresh_timer (params REF_PER):
//   - Down-counter plus REF_REQ/REF_ACK set/clear.
//   - Enabled by INIT_DONE.
//  The FSM, decoder and address register stay in this module.
// TESTING  (INIT_PER=16, REF_PER=32, INIT_REF_CNT=2; responder returns CM_ACK one cycle, 2 cycles after a level rises)
//  1. Release reset -> INIT_REQ=1 for 16 cycles, then PRECHARGE, REFRESH, REFRESH, LOAD_MODE in order.
//     Each level drops after its CM_ACK. INIT_DONE=1 after the LOAD_MODE ack.
//  2. RUN: CMD=001, ADDR=0x12345 held 10 cycles.
//     -> READA=1 and SADDR=0x12345 next cycle.
//     -> READA=0 the cycle after CM_ACK; CMD_ACK is a single-cycle pulse.
//     -> READA stays 0 until CMD=000, then re-arms.
//  3. After INIT_DONE -> REF_REQ=1 at cycle 32. REF_ACK at +5 -> REF_REQ=0 next cycle. Next REF_REQ 32 cycles after the previous one.
//  4. Hold REF_ACK=0 for 70 cycles -> REF_REQ stays 1 throughout. A single REF_ACK clears it.
//  5. CMD=010, ADDR=0x7FF during PWR_WAIT -> WRITEA=0, SADDR=0, CMD_ACK=0.
//  6. Assert RESET_N=0 mid-RUN with WRITEA=1 -> WRITEA=0, INIT_REQ=1, INIT_DONE=0 asynchronously. Init repeats.

Source files
------------

// File: rtl/sdram_control_if_pkg.sv
// Shared encodings, FSM states and helpers for the SDRAM host control interface.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package sdram_pkg;

    // Host command encodings (3'b110 and 3'b111 decode as NOP)
    localparam logic [2:0] CMD_NOP       = 3'b000;
    localparam logic [2:0] CMD_READA     = 3'b001;
    localparam logic [2:0] CMD_WRITEA    = 3'b010;
    localparam logic [2:0] CMD_REFRESH   = 3'b011;
    localparam logic [2:0] CMD_PRECHARGE = 3'b100;
    localparam logic [2:0] CMD_LOAD_MODE = 3'b101;

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_PRE,
        ST_REF,
        ST_ACKLOW,
        ST_LMR,
        ST_RUN
    } state_e;

    // One-hot command levels towards the command stage
    typedef struct packed {
        logic reada;
        logic writea;
        logic refresh;
        logic precharge;
        logic load_mode;
    } cmd_lvl_t;

    // Counter width for a count of n, never narrower than one bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic cmd_lvl_t decode_cmd(input logic [2:0] cmd);
        cmd_lvl_t lvl;
        lvl = '0;
        case (cmd)
            CMD_READA:     lvl.reada     = 1'b1;
            CMD_WRITEA:    lvl.writea    = 1'b1;
            CMD_REFRESH:   lvl.refresh   = 1'b1;
            CMD_PRECHARGE: lvl.precharge = 1'b1;
            CMD_LOAD_MODE: lvl.load_mode = 1'b1;
            default:       lvl           = '0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/sdram_control_if_if.sv
// Host / command-stage signal bundle for sdram_control_if.
// Latency: n/a (wires only).
// Backpressure: CM_ACK and REF_ACK are the command stage's accept signals.
// Ports: CMD/ADDR/CM_ACK/REF_ACK into the block; decoded levels, SADDR,
//        REF_REQ, INIT_REQ, CMD_ACK, INIT_DONE out of the block.
interface sdram_control_if_if #(parameter int ASIZE = 23);
    logic [2:0]       CMD;
    logic [ASIZE-1:0] ADDR;
    logic             CM_ACK;
    logic             REF_ACK;
    logic             NOP;
    logic             READA;
    logic             WRITEA;
    logic             REFRESH;
    logic             PRECHARGE;
    logic             LOAD_MODE;
    logic [ASIZE-1:0] SADDR;
    logic             REF_REQ;
    logic             INIT_REQ;
    logic             CMD_ACK;
    logic             INIT_DONE;

    // Driver side: host plus command stage (testbench or surrounding logic)
    modport master (
        output CMD, ADDR, CM_ACK, REF_ACK,
        input  NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE,
        input  SADDR, REF_REQ, INIT_REQ, CMD_ACK, INIT_DONE
    );

    // The control block itself
    modport slave (
        input  CMD, ADDR, CM_ACK, REF_ACK,
        output NOP, READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE,
        output SADDR, REF_REQ, INIT_REQ, CMD_ACK, INIT_DONE
    );
endinterface

// File: rtl/sdram_control_if_refresh_timer.sv
// Periodic refresh timer: down-counter raising a single held refresh request.
// Latency: request rises on the edge after the counter reaches zero.
// Backpressure: request holds until ref_ack_i is sampled; further expiries do not queue.
// Ports: clk_i, rst_n_i, en_i (counting enable), ref_ack_i in; ref_req_o out.
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REF_PER = 1024
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic ref_ack_i,
    output logic ref_req_o
);
    localparam int            CW     = cnt_w(REF_PER);
    localparam logic [CW-1:0] RELOAD = CW'(REF_PER - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_q, req_d;
    logic          expire;

    always_comb begin
        expire = en_i && (cnt_q == '0);
        cnt_d  = cnt_q;
        req_d  = req_q;
        // Held at the reload value while disabled so the first request
        // lands exactly REF_PER cycles after enable
        if (!en_i || expire) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
        // Expiry dominates a simultaneous acknowledge
        if (expire) begin
            req_d = 1'b1;
        end else if (ref_ack_i) begin
            req_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= RELOAD;
            req_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            req_q <= req_d;
        end
    end

    assign ref_req_o = req_q;
endmodule

// File: rtl/sdram_control_if.sv
// Host control interface ahead of the SDRAM command generator: init sequence, command decode, refresh timer.
// Latency: host command to registered level/SADDR in 1 cycle; CMD_ACK one cycle after CM_ACK is sampled.
// Backpressure: levels hold until CM_ACK; after an accept, the host must return CMD to NOP to re-arm.
// Ports: CLK, RESET_N (async active-low); bus (slave modport) carries CMD/ADDR/CM_ACK/REF_ACK in
//        and NOP, one-hot levels, SADDR, REF_REQ, INIT_REQ, CMD_ACK, INIT_DONE out.
module sdram_control_if
    import sdram_pkg::*;
#(
    parameter int ASIZE        = 23,
    parameter int INIT_PER     = 24000,
    parameter int REF_PER      = 1024,
    parameter int INIT_REF_CNT = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    sdram_control_if_if.slave  bus
);
    localparam int                  INIT_W    = cnt_w(INIT_PER);
    localparam int                  RCNT_W    = cnt_w(INIT_REF_CNT + 1);
    localparam logic [INIT_W-1:0]   INIT_LAST = INIT_W'(INIT_PER - 1);
    localparam logic [RCNT_W-1:0]   REF_TGT   = RCNT_W'(INIT_REF_CNT);

    state_e            state_q, state_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic [RCNT_W-1:0] ref_cnt_q, ref_cnt_d;
    cmd_lvl_t          lvl_q, lvl_d;
    logic [ASIZE-1:0]  saddr_q, saddr_d;
    logic              init_req_q, init_req_d;
    logic              init_done_q, init_done_d;
    logic              cmd_ack_q, cmd_ack_d;
    logic              blocked_q, blocked_d;

    cmd_lvl_t          host_lvl;
    logic              host_nop;

    assign host_lvl = decode_cmd(bus.CMD);
    assign host_nop = (host_lvl == '0);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        ref_cnt_d   = ref_cnt_q;
        lvl_d       = lvl_q;
        saddr_d     = saddr_q;
        init_req_d  = init_req_q;
        init_done_d = init_done_q;
        cmd_ack_d   = 1'b0;
        blocked_d   = blocked_q;

        case (state_q)
            ST_PWR_WAIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    init_req_d      = 1'b0;
                    lvl_d           = '0;
                    lvl_d.precharge = 1'b1;
                    state_d         = ST_PRE;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            ST_PRE: begin
                if (bus.CM_ACK) begin
                    lvl_d.precharge = 1'b0;
                    state_d         = ST_ACKLOW;
                end
            end
            ST_REF: begin
                if (bus.CM_ACK) begin
                    lvl_d.refresh = 1'b0;
                    ref_cnt_d     = ref_cnt_q + RCNT_W'(1);
                    state_d       = ST_ACKLOW;
                end
            end
            ST_ACKLOW: begin
                // The refresh count is still zero straight after PRECHARGE,
                // so one compare covers both "after PRE" and "more refreshes due"
                if (!bus.CM_ACK) begin
                    if (ref_cnt_q < REF_TGT) begin
                        lvl_d.refresh = 1'b1;
                        state_d       = ST_REF;
                    end else begin
                        lvl_d.load_mode = 1'b1;
                        saddr_d         = '0;
                        state_d         = ST_LMR;
                    end
                end
            end
            ST_LMR: begin
                saddr_d = '0;
                if (bus.CM_ACK) begin
                    lvl_d.load_mode = 1'b0;
                    init_done_d     = 1'b1;
                    state_d         = ST_RUN;
                end
            end
            ST_RUN: begin
                if (lvl_q != '0) begin
                    // A level in flight keeps its original command even if
                    // the host changes CMD; only an accept or NOP drops it
                    if (bus.CM_ACK) begin
                        lvl_d     = '0;
                        cmd_ack_d = 1'b1;
                        blocked_d = 1'b1;
                    end else if (host_nop) begin
                        lvl_d = '0;
                    end
                end else if (host_nop) begin
                    blocked_d = 1'b0;
                end else if (!blocked_q) begin
                    lvl_d   = host_lvl;
                    saddr_d = bus.ADDR;
                end
            end
            default: begin
                state_d = ST_PWR_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_PWR_WAIT;
            init_cnt_q  <= '0;
            ref_cnt_q   <= '0;
            lvl_q       <= '0;
            saddr_q     <= '0;
            init_req_q  <= 1'b1;
            init_done_q <= 1'b0;
            cmd_ack_q   <= 1'b0;
            blocked_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            ref_cnt_q   <= ref_cnt_d;
            lvl_q       <= lvl_d;
            saddr_q     <= saddr_d;
            init_req_q  <= init_req_d;
            init_done_q <= init_done_d;
            cmd_ack_q   <= cmd_ack_d;
            blocked_q   <= blocked_d;
        end
    end

    sdram_refresh_timer #(
        .REF_PER (REF_PER)
    ) u_ref_timer (
        .clk_i     (CLK),
        .rst_n_i   (RESET_N),
        .en_i      (init_done_q),
        .ref_ack_i (bus.REF_ACK),
        .ref_req_o (bus.REF_REQ)
    );

    assign bus.READA     = lvl_q.reada;
    assign bus.WRITEA    = lvl_q.writea;
    assign bus.REFRESH   = lvl_q.refresh;
    assign bus.PRECHARGE = lvl_q.precharge;
    assign bus.LOAD_MODE = lvl_q.load_mode;
    assign bus.NOP       = ~|lvl_q;
    assign bus.SADDR     = saddr_q;
    assign bus.INIT_REQ  = init_req_q;
    assign bus.CMD_ACK   = cmd_ack_q;
    assign bus.INIT_DONE = init_done_q;
endmodule

// File: tb/tb_sdram_control_if.sv
// Directed bench for sdram_control_if: init sequence, host handshake, refresh timer, async reset.
// Latency: n/a.
// Backpressure: a responder returns CM_ACK for one cycle, two cycles after any level rises.
module tb_sdram_control_if;
    localparam int ASIZE = 23;

    logic CLK;
    logic RESET_N;
    int   k;
    int   n_total;
    int   n_pass;

    sdram_control_if_if #(.ASIZE(ASIZE)) bus ();

    sdram_control_if #(
        .ASIZE        (ASIZE),
        .INIT_PER     (16),
        .REF_PER      (32),
        .INIT_REF_CNT (2)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // {READA, WRITEA, REFRESH, PRECHARGE, LOAD_MODE}
    function automatic logic [4:0] lv();
        return {bus.READA, bus.WRITEA, bus.REFRESH, bus.PRECHARGE, bus.LOAD_MODE};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s @k=%0d: got 0x%0h, expected 0x%0h", tag, k, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        k++;
    endtask

    task automatic wait_to(input int n);
        while (k < n) tick();
    endtask

    // Hand-derived level timeline for INIT_PER=16, INIT_REF_CNT=2 and the
    // 2-cycle responder: PRE 16-17, REF 19-20, REF 22-23, LMR 25-26
    function automatic logic [4:0] exp_init_lv(input int c);
        if (c == 16 || c == 17) return 5'b00010;
        if (c == 19 || c == 20 || c == 22 || c == 23) return 5'b00100;
        if (c == 25 || c == 26) return 5'b00001;
        return 5'b00000;
    endfunction

    task automatic release_reset();
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        k = 0;
    endtask

    task automatic run_init(input bit host_cmd);
        logic [4:0] e;
        for (int i = 1; i <= 28; i++) begin
            tick();
            e = exp_init_lv(k);
            check("init_lv", 32'(lv()), 32'(e));
            check("init_nop", 32'(bus.NOP), 32'(~|e));
            check("init_req", 32'(bus.INIT_REQ), 32'(k < 16));
            check("init_done", 32'(bus.INIT_DONE), 32'(k >= 27));
            check("init_ref_req", 32'(bus.REF_REQ), 32'd0);
            if (host_cmd && k == 5) begin
                check("pwr_wait_saddr", 32'(bus.SADDR), 32'd0);
                check("pwr_wait_cmd_ack", 32'(bus.CMD_ACK), 32'd0);
            end
            if (host_cmd && k == 10) bus.CMD = 3'b000;
        end
    endtask

    // Command-stage responder
    initial begin
        int   s;
        logic prev;
        s = 0;
        prev = 1'b0;
        bus.CM_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                s = 0;
                prev = 1'b0;
                bus.CM_ACK = 1'b0;
            end else begin
                bus.CM_ACK = (s == 1);
                if (s > 0) s--;
                if (lv() != 5'b0 && !prev) s = 1;
                prev = (lv() != 5'b0);
            end
        end
    end

    initial begin
        n_total = 0;
        n_pass  = 0;
        k       = 0;
        RESET_N = 1'b0;
        bus.CMD = 3'b000;
        bus.ADDR = '0;
        bus.REF_ACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        check("rst_init_req", 32'(bus.INIT_REQ), 32'd1);
        check("rst_nop", 32'(bus.NOP), 32'd1);
        check("rst_lv", 32'(lv()), 32'd0);
        check("rst_saddr", 32'(bus.SADDR), 32'd0);
        check("rst_ref_req", 32'(bus.REF_REQ), 32'd0);
        check("rst_cmd_ack", 32'(bus.CMD_ACK), 32'd0);
        check("rst_init_done", 32'(bus.INIT_DONE), 32'd0);

        // Host command presented during power-up wait must be ignored
        bus.CMD  = 3'b010;
        bus.ADDR = 23'h7FF;
        release_reset();
        run_init(1'b1);

        // READA handshake
        wait_to(29);
        bus.CMD  = 3'b001;
        bus.ADDR = 23'h12345;
        wait_to(30);
        check("rd_lv", 32'(lv()), 32'b10000);
        check("rd_saddr", 32'(bus.SADDR), 32'h12345);
        check("rd_nop", 32'(bus.NOP), 32'd0);
        check("rd_cmd_ack0", 32'(bus.CMD_ACK), 32'd0);
        wait_to(31);
        check("rd_hold", 32'(lv()), 32'b10000);
        check("rd_cmd_ack1", 32'(bus.CMD_ACK), 32'd0);
        wait_to(32);
        check("rd_drop", 32'(lv()), 32'd0);
        check("rd_cmd_ack_pulse", 32'(bus.CMD_ACK), 32'd1);
        check("rd_nop_back", 32'(bus.NOP), 32'd1);
        wait_to(33);
        check("rd_cmd_ack_end", 32'(bus.CMD_ACK), 32'd0);
        check("rd_blocked", 32'(lv()), 32'd0);
        wait_to(39);
        check("rd_blocked_late", 32'(lv()), 32'd0);
        // Change command without a NOP in between: still blocked
        bus.CMD  = 3'b010;
        bus.ADDR = 23'h7FF;
        wait_to(42);
        check("chg_blocked", 32'(lv()), 32'd0);
        check("chg_saddr", 32'(bus.SADDR), 32'h12345);
        check("chg_cmd_ack", 32'(bus.CMD_ACK), 32'd0);
        bus.CMD = 3'b000;
        wait_to(43);
        check("nop_idle", 32'(lv()), 32'd0);
        check("nop_out", 32'(bus.NOP), 32'd1);
        bus.CMD = 3'b010;
        wait_to(44);
        check("wr_rearm", 32'(lv()), 32'b01000);
        check("wr_saddr", 32'(bus.SADDR), 32'h7FF);
        wait_to(46);
        check("wr_drop", 32'(lv()), 32'd0);
        check("wr_cmd_ack", 32'(bus.CMD_ACK), 32'd1);
        bus.CMD = 3'b000;
        wait_to(47);
        check("wr_cmd_ack_end", 32'(bus.CMD_ACK), 32'd0);
        // 11x decodes as NOP
        bus.CMD = 3'b110;
        wait_to(49);
        check("cmd110_nop", 32'(lv()), 32'd0);
        check("cmd110_nop_out", 32'(bus.NOP), 32'd1);
        bus.CMD = 3'b011;
        wait_to(50);
        check("host_refresh", 32'(lv()), 32'b00100);
        wait_to(52);
        check("host_refresh_drop", 32'(lv()), 32'd0);
        check("host_refresh_ack", 32'(bus.CMD_ACK), 32'd1);
        bus.CMD = 3'b000;

        // Refresh timer: INIT_DONE at 27, first request at 27+32
        wait_to(58);
        check("ref_before", 32'(bus.REF_REQ), 32'd0);
        wait_to(59);
        check("ref_first", 32'(bus.REF_REQ), 32'd1);
        wait_to(63);
        check("ref_held", 32'(bus.REF_REQ), 32'd1);
        bus.REF_ACK = 1'b1;
        wait_to(64);
        check("ref_cleared", 32'(bus.REF_REQ), 32'd0);
        bus.REF_ACK = 1'b0;
        wait_to(90);
        check("ref_gap", 32'(bus.REF_REQ), 32'd0);
        wait_to(91);
        check("ref_second", 32'(bus.REF_REQ), 32'd1);
        // No acknowledge for 70 cycles spanning two expiries
        for (int i = 0; i < 70; i++) begin
            tick();
            check("ref_no_ack_hold", 32'(bus.REF_REQ), 32'd1);
        end
        bus.REF_ACK = 1'b1;
        wait_to(162);
        check("ref_single_ack", 32'(bus.REF_REQ), 32'd0);
        bus.REF_ACK = 1'b0;
        wait_to(186);
        check("ref_gap2", 32'(bus.REF_REQ), 32'd0);
        wait_to(187);
        check("ref_after_hold", 32'(bus.REF_REQ), 32'd1);
        // Acknowledge sampled on the expiry edge (219): expiry wins
        wait_to(218);
        bus.REF_ACK = 1'b1;
        wait_to(219);
        check("ref_expiry_wins", 32'(bus.REF_REQ), 32'd1);
        wait_to(220);
        check("ref_clear_after", 32'(bus.REF_REQ), 32'd0);
        bus.REF_ACK = 1'b0;

        // Asynchronous reset while WRITEA is up
        bus.CMD  = 3'b010;
        bus.ADDR = 23'h55;
        wait_to(221);
        check("mid_wr_lv", 32'(lv()), 32'b01000);
        check("mid_wr_saddr", 32'(bus.SADDR), 32'h55);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_writea", 32'(bus.WRITEA), 32'd0);
        check("arst_init_req", 32'(bus.INIT_REQ), 32'd1);
        check("arst_init_done", 32'(bus.INIT_DONE), 32'd0);
        check("arst_saddr", 32'(bus.SADDR), 32'd0);
        check("arst_nop", 32'(bus.NOP), 32'd1);
        bus.CMD = 3'b000;
        repeat (2) @(posedge CLK);
        release_reset();
        run_init(1'b0);
        wait_to(58);
        check("reinit_ref_before", 32'(bus.REF_REQ), 32'd0);
        wait_to(59);
        check("reinit_ref_first", 32'(bus.REF_REQ), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
